// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    UPDATE = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INCR                = 4;
  localparam logic [31:0] DEFAULT_RESET_PC       = 32'h0040_0000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  // Word fetches require the two address LSBs to be zero.
  function automatic logic is_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts REQ cycles without an ack; expired flags the cycle whose increment reaches LIMIT.
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = en && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch: PC -> mem req/ack -> instr register, PC+4 writeback.
// Optional mem_ack timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH      = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC       = BIT_WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [BIT_WIDTH-1:0] pc,
  output logic                 mem_req,
  output logic [BIT_WIDTH-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  output logic [BIT_WIDTH-1:0] instr,
  output logic [BIT_WIDTH-1:0] pc_next,
  output logic                 pc_en,
  output logic                 done,
  output logic                 fault,
  output logic                 busy
);

  fetch_state_t state_q, state_d;

  logic [BIT_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BIT_WIDTH-1:0] pc_next_q, pc_next_d;
  logic [BIT_WIDTH-1:0] instr_q, instr_d;
  logic                 mem_req_q, mem_req_d;
  logic                 pc_en_q, pc_en_d;
  logic                 done_q, done_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic                 timeout_c;

`ifdef FETCH_TIMEOUT_EN
  logic tmo_clear_c;
  logic tmo_en_c;

  // Clear on the IDLE->REQ transition so every fetch gets a fresh budget.
  assign tmo_clear_c = (state_q == IDLE) && start && !flush && is_aligned(pc[1:0]);
  assign tmo_en_c    = (state_q == REQ) && !mem_ack;

  fetch_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear_c),
    .en     (tmo_en_c),
    .expired(timeout_c)
  );
`else
  logic unused_timeout_cfg;

  assign timeout_c          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and next-register values; flush beats ack, ack beats timeout.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    pc_next_d  = pc_next_q;
    instr_d    = instr_q;
    fault_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          mem_addr_d = pc;
          pc_next_d  = pc + BIT_WIDTH'(PC_INCR);
          if (is_aligned(pc[1:0])) begin
            state_d = REQ;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = UPDATE;
        end else if (timeout_c) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_req_d = (state_d == REQ);
    busy_d    = (state_d != IDLE);
    pc_en_d   = (state_d == UPDATE);
    done_d    = (state_d == UPDATE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_addr_q <= RESET_PC;
      pc_next_q  <= RESET_PC;
      instr_q    <= '0;
      mem_req_q  <= 1'b0;
      pc_en_q    <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      pc_next_q  <= pc_next_d;
      instr_q    <= instr_d;
      mem_req_q  <= mem_req_d;
      pc_en_q    <= pc_en_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign instr    = instr_q;
  assign pc_next  = pc_next_q;
  assign pc_en    = pc_en_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign busy     = busy_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multicycle instruction-fetch sequencer that reads the program counter, fetches the addressed word from instruction memory over a req/ack handshake, and latches it in the instruction register. It also writes PC+4 back to the PC register through its write-data/enable pair. It sits between the PC register, instruction memory and the main control FSM, and is the consumer/updater side of the PC register's Read_Data/Write_Data/en interface.

## Interface
- BIT_WIDTH, 32, width of PC, address and instruction
- RESET_PC, 32'h00400000, reset vector; reset value of mem_addr and pc_next
- TIMEOUT_CYCLES, 16, max cycles waiting for mem_ack (used only with timeout feature)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  control FSM requests one fetch; sampled only in IDLE
- flush  in  1  abort current fetch; wins over start and mem_ack
- pc  in  BIT_WIDTH  current PC (PC register Read_Data)
- mem_req  out  1  read request, held until ack
- mem_addr  out  BIT_WIDTH  read address, stable while mem_req=1
- mem_ack  in  1  memory ack; mem_rdata valid same cycle
- mem_rdata  in  BIT_WIDTH  fetched word
- instr  out  BIT_WIDTH  instruction register
- pc_next  out  BIT_WIDTH  PC write data (to PC Write_Data)
- pc_en  out  1  one-cycle PC write enable (to PC en)
- done  out  1  one-cycle pulse, fetch completed
- fault  out  1  one-cycle pulse, fetch aborted by error
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, REQ, UPDATE.
- IDLE: start=1 and flush=0 -> latch pc into mem_addr, compute pc_next=pc+4 (modulo 2^BIT_WIDTH, 32'hFFFFFFFC wraps to 0). If pc[1:0]!=0 -> fault pulse next cycle, stay IDLE, no mem_req, no pc_en, mem_addr/pc_next still updated. Otherwise -> REQ.
- REQ: mem_req=1. mem_ack=1 and flush=0 -> instr<=mem_rdata, go UPDATE. flush=1 -> IDLE, instr unchanged, ack in same cycle ignored.
- UPDATE: pc_en=1, done=1 for exactly one cycle -> IDLE.
- start outside IDLE ignored; mem_ack outside REQ ignored.
- flush in IDLE or UPDATE: no effect (UPDATE completes).
- All outputs registered or decoded from state only; no combinational path from inputs to outputs.
- rst (any state, including mid-REQ): state IDLE, mem_req=0, pc_en=0, done=0, fault=0, busy=0, instr=0, mem_addr=RESET_PC, pc_next=RESET_PC. A pending memory ack after reset is ignored.

## Timing
- start sampled edge 0 -> mem_req=1, busy=1 in cycle 1.
- mem_ack sampled at edge k -> instr valid, pc_en=done=1 in cycle k+1, mem_req=0 in cycle k+1.
- Minimum latency start->done: 2 cycles (ack in cycle 1).
- Back-to-back: start may be reasserted in the cycle after done; next mem_req 1 cycle later.
- Misaligned pc: fault pulse in cycle 1, busy stays 0.

## Configuration
- FETCH_TIMEOUT_EN defined: cycle counter cleared on REQ entry, incremented each REQ cycle without ack. When count reaches TIMEOUT_CYCLES, go IDLE, pulse fault, drop mem_req, and generate no pc_en. An ack on the same edge as expiry wins.
- Undefined: no counter, REQ waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Package fetch_pkg: state enum fetch_state_t (IDLE, REQ, UPDATE), PC_INCR=4, default RESET_PC constant.
- One sub-module, fetch_timeout_ctr (clear/enable/expired), instantiated only under FETCH_TIMEOUT_EN.
- Top-level is FSM plus address/instruction/pc_next registers.

## Test plan
- Reset: assert rst mid-REQ -> next cycle mem_req=0, instr=0, mem_addr=pc_next=32'h00400000, busy=0.
- Normal fetch: pc=32'h00400000, start, ack 3 cycles later with rdata=32'h2008000A -> instr=32'h2008000A, pc_next=32'h00400004, single pc_en/done pulse.
- Misaligned: pc=32'h00400002, start -> fault pulse next cycle, no mem_req, no pc_en.
- Flush race: in REQ, flush and mem_ack same cycle -> IDLE, instr unchanged, no pc_en.
- Wrap and back-to-back: pc=32'hFFFFFFFC, ack immediately -> pc_next=0, done at cycle 2. Start reasserted next cycle -> second fetch proceeds.
- FETCH_TIMEOUT_EN: no ack for 16 REQ cycles -> fault pulse, mem_req drops, no pc_en. Ack on the 16th cycle -> normal completion.
